bd_if_multi: RTL and testbench



---
 rtl/bd_if_multi_if.sv | 38 +++
 rtl/bd_if_multi.sv | 248 ++++++++++++++++++++++++
 tb/tb_bd_if_multi.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bd_if_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : bd_if_multi_if
//  Description : Board-side bundle for bd_if_multi. It carries the raw
//                buttons, the per-channel press/release pulses, the key
//                encoder outputs, the LED stretcher and the 7-segment digit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bd_if_multi_if #(
    parameter int N_BT  = 10,
    parameter int KEY_W = 4
);
    logic [N_BT-1:0]  bt_i;
    logic [N_BT-1:0]  bt_o;
    logic [N_BT-1:0]  bt_rel_o;
    logic             key_vld_o;
    logic [KEY_W-1:0] key_code_o;
    logic             key_long_o;
    logic             key_err_o;
    logic             led_i;
    logic             led_o;
    logic [6:0]       fnd_o;

    // Board / stimulus side: drives the pins, observes the decoded results
    modport master (
        output bt_i, led_i,
        input  bt_o, bt_rel_o, key_vld_o, key_code_o, key_long_o, key_err_o,
               led_o, fnd_o
    );

    // Block side: consumes the pins, produces the decoded results
    modport slave (
        input  bt_i, led_i,
        output bt_o, bt_rel_o, key_vld_o, key_code_o, key_long_o, key_err_o,
               led_o, fnd_o
    );
endinterface
`default_nettype wire

// File: rtl/bd_if_multi.sv
`default_nettype none
// ============================================================================
//  Module      : bd_if_multi
//  Description : Parametrised button front end for the DE0 door lock.
//                Per channel: 2-FF sync, debounce, press/release pulses.
//                Shared: single-press key encoder with multi-press error,
//                long-press detector, registered 7-seg of the last key and
//                a retriggerable LED pulse stretcher.
//  Revision    : 1.0 - initial release
// ============================================================================
module bd_if_multi #(
    parameter int N_BT    = 10,
    parameter int KEY_W   = 4,
    parameter int ACT_LOW = 1,
    parameter int T_DEB   = 1_000_000,
    parameter int DEB_W   = 20,
    parameter int T_LONG  = 50_000_000,
    parameter int LONG_W  = 26,
    parameter int T_LED   = 50_000_000,
    parameter int LED_W   = 26
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bd_if_multi_if.slave      bus
);

    localparam logic [KEY_W-1:0]  c_key_none = '1;
    localparam logic [DEB_W-1:0]  c_deb_last = DEB_W'(T_DEB - 1);
    localparam logic [LONG_W-1:0] c_long_last = LONG_W'(T_LONG - 1);
    localparam logic [LED_W-1:0]  c_led_load = LED_W'(T_LED);
    localparam logic [6:0]        c_fnd_blank = 7'h7F;
    localparam logic [6:0]        c_fnd_dash  = 7'h3F;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [N_BT-1:0]   r_sync1;
    logic [N_BT-1:0]   r_sync2;
    logic [N_BT-1:0]   r_stable;
    logic [N_BT-1:0]   r_prev;
    logic [DEB_W-1:0]  r_deb_cnt [N_BT];
    logic [N_BT-1:0]   r_bt_o;
    logic [N_BT-1:0]   r_bt_rel;
    logic              r_key_vld;
    logic              r_key_err;
    logic [KEY_W-1:0]  r_key_code;
    logic [1:0]        r_state;
    logic [LONG_W-1:0] r_long_cnt;
    logic [N_BT-1:0]   r_key_sel;
    logic              r_key_long;
    logic [6:0]        r_fnd;
    logic [LED_W-1:0]  r_led_cnt;

    logic [N_BT-1:0]   w_pin_act;
    logic [N_BT-1:0]   w_press;
    logic [N_BT-1:0]   w_release;
    logic              w_seen;
    logic              w_multi;
    logic              w_single;
    logic [KEY_W-1:0]  w_idx;
    logic              w_held;

    // Polarity is normalised at the pin so the synchroniser's reset value of
    // 0 always means "released"; a button held through reset then debounces
    // like a fresh press instead of producing a phantom edge.
    assign w_pin_act = (ACT_LOW != 0) ? ~bus.bt_i : bus.bt_i;

    // Two-flop synchroniser per channel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pin_act;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: stable follows sync only after T_DEB consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
            for (int i = 0; i < N_BT; i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_BT; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == c_deb_last) begin
                    r_deb_cnt[i] <= '0;
                    r_stable[i]  <= r_sync2[i];
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press   =  r_stable & ~r_prev;
    assign w_release = ~r_stable &  r_prev;

    // Registered press/release pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev   <= '0;
            r_bt_o   <= '0;
            r_bt_rel <= '0;
        end else begin
            r_prev   <= r_stable;
            r_bt_o   <= w_press;
            r_bt_rel <= w_release;
        end
    end

    // Classify this cycle's presses: none, exactly one (with its index), or several
    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N_BT; i++) begin
            if (w_press[i]) begin
                w_multi = w_multi | w_seen;
                w_seen  = 1'b1;
                w_idx   = KEY_W'(i);
            end
        end
    end

    assign w_single = w_seen & ~w_multi;

    // Key encoder, aligned with the bt_o pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_vld  <= 1'b0;
            r_key_err  <= 1'b0;
            r_key_code <= c_key_none;
        end else begin
            r_key_vld <= w_single;
            r_key_err <= w_multi;
            if (w_single) begin
                r_key_code <= w_idx;
            end else if (w_multi) begin
                r_key_code <= c_key_none;
            end
        end
    end

    // The accepted key is tracked as a one-hot mask so no index decode is needed
    assign w_held = |(r_stable & r_key_sel);

    // Long-press FSM: one key_long pulse per press after T_LONG cycles of hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_long_cnt <= '0;
            r_key_sel  <= '0;
            r_key_long <= 1'b0;
        end else begin
            r_key_long <= 1'b0;
            if (w_single) begin
                r_state    <= S_HOLD;
                r_long_cnt <= '0;
                r_key_sel  <= w_press;
            end else if (w_multi) begin
                r_state    <= S_IDLE;
                r_long_cnt <= '0;
            end else begin
                case (r_state)
                    S_HOLD: begin
                        if (!w_held) begin
                            r_state <= S_IDLE;
                        end else if (r_long_cnt == c_long_last) begin
                            r_key_long <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_long_cnt <= r_long_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (!w_held) r_state <= S_IDLE;
                    end
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = c_fnd_blank;
        endcase
        return seg;
    endfunction

    // 7-segment digit: follows the encoder one cycle later, dash on error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fnd <= c_fnd_blank;
        end else if (r_key_vld) begin
            r_fnd <= seg7(r_key_code[3:0]);
        end else if (r_key_err) begin
            r_fnd <= c_fnd_dash;
        end
    end

    // LED stretcher: any high trigger cycle reloads, otherwise count down to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led_cnt <= '0;
        end else if (bus.led_i) begin
            r_led_cnt <= c_led_load;
        end else if (r_led_cnt != '0) begin
            r_led_cnt <= r_led_cnt - 1'b1;
        end
    end

    assign bus.bt_o       = r_bt_o;
    assign bus.bt_rel_o   = r_bt_rel;
    assign bus.key_vld_o  = r_key_vld;
    assign bus.key_code_o = r_key_code;
    assign bus.key_long_o = r_key_long;
    assign bus.key_err_o  = r_key_err;
    assign bus.led_o      = (r_led_cnt != '0);
    assign bus.fnd_o      = r_fnd;

endmodule
`default_nettype wire

// File: tb/tb_bd_if_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bd_if_multi
//  Description : Directed self-checking bench for bd_if_multi with short
//                timing parameters (T_DEB=4, T_LONG=16, T_LED=8, active-low).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bd_if_multi;

    localparam int N_BT  = 10;
    localparam int KEY_W = 4;
    localparam int BOUND = 40;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    bd_if_multi_if #(.N_BT(N_BT), .KEY_W(KEY_W)) bus ();

    bd_if_multi #(
        .N_BT   (N_BT),
        .KEY_W  (KEY_W),
        .ACT_LOW(1),
        .T_DEB  (4),
        .DEB_W  (4),
        .T_LONG (16),
        .LONG_W (6),
        .T_LED  (8),
        .LED_W  (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until the selected output is high; n = number of edges taken
    // which: 0 = bt_o[ch], 1 = bt_rel_o[ch], 2 = key_err_o, 3 = key_long_o
    task automatic wait_sig(input int which, input int ch, output int n);
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < BOUND) begin
            step();
            n++;
            case (which)
                0:       hit = bus.bt_o[ch];
                1:       hit = bus.bt_rel_o[ch];
                2:       hit = bus.key_err_o;
                default: hit = bus.key_long_o;
            endcase
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_code"}, 32'(bus.key_code_o), 32'hF);
        chk({tag, "_fnd"},  32'(bus.fnd_o),      32'h7F);
        chk({tag, "_led"},  32'(bus.led_o),      32'h0);
        chk({tag, "_bt"},   32'(bus.bt_o),       32'h0);
        chk({tag, "_rel"},  32'(bus.bt_rel_o),   32'h0);
        chk({tag, "_vld"},  32'(bus.key_vld_o),  32'h0);
        chk({tag, "_err"},  32'(bus.key_err_o),  32'h0);
        chk({tag, "_long"}, 32'(bus.key_long_o), 32'h0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cnt_v;
        int cnt_l;
        logic [N_BT-1:0] any;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.bt_i  = '1;
        bus.led_i = 1'b0;

        // 1. Reset values
        repeat (3) step();
        chk_reset_outputs("t1_rst");
        rst = 1'b0;
        any = '0;
        repeat (6) begin
            step();
            any = any | bus.bt_o;
        end
        chk("t1_no_phantom", 32'(any), 32'h0);

        // 2. Glitch of 3 cycles is filtered, real press encodes key 3
        bus.bt_i[3] = 1'b0;
        repeat (3) step();
        bus.bt_i[3] = 1'b1;
        any = '0;
        repeat (12) begin
            step();
            any = any | bus.bt_o | bus.bt_rel_o;
        end
        chk("t2_glitch", 32'(any), 32'h0);
        bus.bt_i[3] = 1'b0;
        wait_sig(0, 3, n);
        chk("t2_press_lat", 32'(n), 32'd7);
        chk("t2_bt_o", 32'(bus.bt_o), 32'h008);
        chk("t2_vld", 32'(bus.key_vld_o), 32'h1);
        chk("t2_code", 32'(bus.key_code_o), 32'h3);
        step();
        chk("t2_fnd", 32'(bus.fnd_o), 32'h30);
        chk("t2_vld_1cyc", 32'(bus.key_vld_o), 32'h0);
        step();
        step();
        bus.bt_i[3] = 1'b1;
        wait_sig(1, 3, n);
        chk("t2_rel_lat", 32'(n), 32'd7);
        chk("t2_rel_vld", 32'(bus.key_vld_o), 32'h0);
        repeat (5) step();

        // 3. Two presses on the same edge -> error
        bus.bt_i[2] = 1'b0;
        bus.bt_i[7] = 1'b0;
        wait_sig(2, 0, n);
        chk("t3_err_lat", 32'(n), 32'd7);
        chk("t3_bt_o", 32'(bus.bt_o), 32'h084);
        chk("t3_vld", 32'(bus.key_vld_o), 32'h0);
        chk("t3_code", 32'(bus.key_code_o), 32'hF);
        step();
        chk("t3_fnd", 32'(bus.fnd_o), 32'h3F);
        chk("t3_err_1cyc", 32'(bus.key_err_o), 32'h0);
        cnt_l = 0;
        repeat (30) begin
            step();
            cnt_l += int'(bus.key_long_o);
        end
        chk("t3_no_long", 32'(cnt_l), 32'd0);
        bus.bt_i[2] = 1'b1;
        bus.bt_i[7] = 1'b1;
        repeat (15) step();

        // 4a. Long hold of key 9 -> exactly one key_long 16 cycles after vld
        bus.bt_i[9] = 1'b0;
        wait_sig(0, 9, n);
        chk("t4_press_lat", 32'(n), 32'd7);
        chk("t4_vld", 32'(bus.key_vld_o), 32'h1);
        chk("t4_code", 32'(bus.key_code_o), 32'h9);
        step();
        chk("t4_fnd", 32'(bus.fnd_o), 32'h10);
        n = 1;
        while (!bus.key_long_o && n < BOUND) begin
            step();
            n++;
        end
        chk("t4_long_lat", 32'(n), 32'd16);
        cnt_l = 0;
        repeat (17) begin
            step();
            cnt_l += int'(bus.key_long_o);
        end
        chk("t4_long_once", 32'(cnt_l), 32'd0);
        bus.bt_i[9] = 1'b1;
        repeat (15) step();

        // 4b. Short hold of key 9 -> accepted but no long press
        cnt_v = 0;
        cnt_l = 0;
        bus.bt_i[9] = 1'b0;
        repeat (10) begin
            step();
            cnt_v += int'(bus.key_vld_o);
            cnt_l += int'(bus.key_long_o);
        end
        bus.bt_i[9] = 1'b1;
        repeat (40) begin
            step();
            cnt_v += int'(bus.key_vld_o);
            cnt_l += int'(bus.key_long_o);
        end
        chk("t4_short_vld", 32'(cnt_v), 32'd1);
        chk("t4_short_long", 32'(cnt_l), 32'd0);

        // 5. LED stretch and retrigger
        bus.led_i = 1'b1;
        step();
        bus.led_i = 1'b0;
        n = 0;
        while (bus.led_o && n < BOUND) begin
            n++;
            step();
        end
        chk("t5_led_len", 32'(n), 32'd8);
        repeat (3) step();
        bus.led_i = 1'b1;
        step();
        bus.led_i = 1'b0;
        repeat (4) step();
        chk("t5_led_mid", 32'(bus.led_o), 32'h1);
        bus.led_i = 1'b1;
        step();
        bus.led_i = 1'b0;
        n = 0;
        while (bus.led_o && n < BOUND) begin
            n++;
            step();
        end
        chk("t5_retrig_len", 32'(n), 32'd8);

        // 6. Reset during HOLD with LED running, then re-debounce held key
        bus.bt_i[5] = 1'b0;
        wait_sig(0, 5, n);
        chk("t6_press_lat", 32'(n), 32'd7);
        repeat (3) step();
        bus.led_i = 1'b1;
        step();
        bus.led_i = 1'b0;
        chk("t6_led_on", 32'(bus.led_o), 32'h1);
        rst = 1'b1;
        step();
        chk_reset_outputs("t6_rst");
        rst = 1'b0;
        wait_sig(0, 5, n);
        chk("t6_repress_lat", 32'(n), 32'd7);
        chk("t6_vld", 32'(bus.key_vld_o), 32'h1);
        chk("t6_code", 32'(bus.key_code_o), 32'h5);
        bus.bt_i[5] = 1'b1;
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
